vga_fb_arbiter: RTL and testbench
=================================

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 19, the framebuffer word-address width.
REQ-002 The block SHALL take parameter DATA_W, default 24, the pixel width (8-bit R, G, B).
REQ-003 The block SHALL take parameter WR_MAX_WAIT, default 16, the writer starvation limit in cycles (range 1..255).
REQ-004 clk  in  1  single clock; all logic on posedge; one clock, no other domains.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 frame_start  in  1  one-cycle pulse at start of each frame, from the timing generator; clears f_underrun.
REQ-007 f_req  in  1  display-fetch read request; f_addr  in  ADDR_W  fetch address.
REQ-008 f_gnt  out  1  fetch request accepted this cycle (combinational).
REQ-009 f_rvalid  out  1  fetch read data valid; f_rdata  out  DATA_W  fetch read data.
REQ-010 w_req  in  1  writer request; w_we  in  1  1=write, 0=read; w_addr  in  ADDR_W; w_wdata  in  DATA_W.
REQ-011 w_gnt  out  1  writer request accepted this cycle (combinational).
REQ-012 w_rvalid  out  1  writer read data valid; w_rdata  out  DATA_W.
REQ-013 m_en, m_we  out  1 each; m_addr  out  ADDR_W; m_wdata  out  DATA_W  registered single-port SRAM command.
REQ-014 m_rdata  in  DATA_W  SRAM read data, valid exactly one cycle after m_en with m_we=0.
REQ-015 f_underrun  out  1  sticky: a fetch request was refused during the current frame.

Function
REQ-016 Exactly one grant SHALL be issued per cycle at most; f_gnt and w_gnt SHALL never both be 1.
REQ-017 FSM states: NORMAL and STARVE; reset state NORMAL.
REQ-018 In NORMAL: f_req=1 -> f_gnt=1; else w_req=1 -> w_gnt=1.
REQ-019 In STARVE: w_req=1 -> w_gnt=1 and f_gnt=0; after that grant the next state SHALL be NORMAL.
REQ-020 STARVE with w_req=0 SHALL behave as NORMAL and return to NORMAL next cycle.
REQ-021 Wait counter (8 bit): increments, saturating at WR_MAX_WAIT, each cycle with w_req=1 and w_gnt=0; cleared on w_gnt=1 or w_req=0.
REQ-022 NORMAL -> STARVE when the counter equals WR_MAX_WAIT at a clock edge with w_req=1 and w_gnt=0; the counter reaching the limit in the same cycle as a W grant SHALL NOT enter STARVE.
REQ-023 Cycle t grant -> at t+1 m_en=1, m_addr/m_we/m_wdata from the granted port (m_we=0 for fetch); no grant -> m_en=0, m_we=0, other m_* hold.
REQ-024 Reads: rvalid of the owning port asserted at t+2 for one cycle; rdata = m_rdata passthrough, routed by a registered 2-stage owner tag; writes produce no rvalid.
REQ-025 Back-to-back grants every cycle SHALL be supported (full throughput, one access per cycle).
REQ-026 f_underrun SET when f_req=1 and f_gnt=0; CLEARED by frame_start; simultaneous set and frame_start -> f_underrun=1.
REQ-027 Non-owning port rvalid SHALL be 0; rdata of a port is don't-care while its rvalid=0.

Reset
REQ-028 Reset SHALL set m_en=0, m_we=0, m_addr=0, m_wdata=0, f_rvalid=0, w_rvalid=0, f_underrun=0, wait counter=0, owner tags=none, state NORMAL.
REQ-029 While reset=1, f_gnt=0 and w_gnt=0.
REQ-030 Reset mid-operation SHALL discard in-flight reads: no rvalid in the two cycles after reset deasserts unless newly granted.

Structure
REQ-031 Shared package vga_fb_pkg SHALL hold the FSM state encoding, owner-tag encoding (NONE, F, W) and default ADDR_W/DATA_W.
REQ-032 The wait counter and STARVE decision SHALL be one sub-module, fb_starve_timer (in: w_req, w_gnt; out: starve); arbitration and pipeline remain in vga_fb_arbiter.

Verification
REQ-033 f_req=1 at addr 0x00010, w_req=0 -> f_gnt same cycle, m_en=1 m_addr=0x00010 at t+1, f_rvalid=1 with m_rdata at t+2.
REQ-034 f_req and w_req held 1 continuously, WR_MAX_WAIT=16 -> w_gnt exactly once every 18 cycles, f_gnt in all other cycles, f_underrun=1 after first W grant.
REQ-035 w_req=1 w_we=1 addr 0x12345 data 0xFF8000, f_req=0 -> w_gnt same cycle, m_we=1 m_wdata=0xFF8000 at t+1, no w_rvalid.
REQ-036 Alternating F read / W read every cycle -> f_rvalid and w_rvalid alternate with correct data, never both 1.
REQ-037 frame_start pulse in same cycle as a refused f_req -> f_underrun stays 1; frame_start alone next frame -> f_underrun=0.
REQ-038 reset asserted one cycle after an F read grant -> no f_rvalid afterwards, all outputs at reset values.

Source files
------------

// File: rtl/vga_fb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | vga_fb_pkg: shared encodings for the framebuffer arbiter       |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
package vga_fb_pkg;

  localparam int ADDR_W_DEF = 19;
  localparam int DATA_W_DEF = 24;

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_STARVE = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_F    = 2'd1,
    OWN_W    = 2'd2
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/fb_starve_timer.sv
`default_nettype none
// +----------------------------------------------------------------+
// | fb_starve_timer: writer wait counter and NORMAL/STARVE FSM     |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module fb_starve_timer
  import vga_fb_pkg::*;
#(
  parameter int WR_MAX_WAIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic w_req,
  input  logic w_gnt,
  output logic starve
);

  localparam logic [7:0] LIMIT = 8'(WR_MAX_WAIT);

  logic [7:0] wait_cnt;
  state_t     state;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 8'd0;
      state    <= ST_NORMAL;
    end else begin
      if (w_req && !w_gnt)
        wait_cnt <= (wait_cnt == LIMIT) ? wait_cnt : wait_cnt + 8'd1;
      else
        wait_cnt <= 8'd0;

      // STARVE lasts one cycle: either the writer is served or it went away.
      case (state)
        ST_NORMAL: if (w_req && !w_gnt && wait_cnt == LIMIT) state <= ST_STARVE;
        ST_STARVE: state <= ST_NORMAL;
        default:   state <= ST_NORMAL;
      endcase
    end
  end

  assign starve = (state == ST_STARVE);

endmodule
`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------+
// | vga_fb_arbiter: display-fetch / writer arbiter for one SRAM    |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WR_MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              w_req,
  input  logic              w_we,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_wdata,
  output logic              w_gnt,
  output logic              w_rvalid,
  output logic [DATA_W-1:0] w_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              f_underrun
);

  logic   starve;
  owner_t tag_s1;
  owner_t tag_s2;

  // Fetch wins unless the writer has been starved and is still asking.
  assign f_gnt = !reset && f_req && !(starve && w_req);
  assign w_gnt = !reset && w_req && (starve || !f_req);

  fb_starve_timer #(
    .WR_MAX_WAIT(WR_MAX_WAIT)
  ) u_starve_timer (
    .clk   (clk),
    .reset (reset),
    .w_req (w_req),
    .w_gnt (w_gnt),
    .starve(starve)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      m_en       <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      tag_s1     <= OWN_NONE;
      tag_s2     <= OWN_NONE;
      f_underrun <= 1'b0;
    end else begin
      m_en <= f_gnt | w_gnt;
      if (f_gnt) begin
        m_we   <= 1'b0;
        m_addr <= f_addr;
      end else if (w_gnt) begin
        m_we    <= w_we;
        m_addr  <= w_addr;
        m_wdata <= w_wdata;
      end else begin
        m_we <= 1'b0;
      end

      if (f_gnt)
        tag_s1 <= OWN_F;
      else if (w_gnt && !w_we)
        tag_s1 <= OWN_W;
      else
        tag_s1 <= OWN_NONE;
      tag_s2 <= tag_s1;

      // A refusal in the same cycle as frame_start belongs to the new frame.
      if (f_req && !f_gnt)
        f_underrun <= 1'b1;
      else if (frame_start)
        f_underrun <= 1'b0;
    end
  end

  assign f_rvalid = (tag_s2 == OWN_F);
  assign w_rvalid = (tag_s2 == OWN_W);
  assign f_rdata  = m_rdata;
  assign w_rdata  = m_rdata;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_vga_fb_arbiter: directed bench with read-data scoreboard    |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        f_req;
  logic [18:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [23:0] f_rdata;
  logic        w_req;
  logic        w_we;
  logic [18:0] w_addr;
  logic [23:0] w_wdata;
  logic        w_gnt;
  logic        w_rvalid;
  logic [23:0] w_rdata;
  logic        m_en;
  logic        m_we;
  logic [18:0] m_addr;
  logic [23:0] m_wdata;
  logic [23:0] m_rdata = 24'd0;
  logic        f_underrun;

  int ncmp = 0;
  int nerr = 0;
  int cyc  = 0;

  typedef struct {
    logic        port;
    logic [23:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;

  vga_fb_arbiter #(
    .ADDR_W(19), .DATA_W(24), .WR_MAX_WAIT(16)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .w_req(w_req), .w_we(w_we), .w_addr(w_addr), .w_wdata(w_wdata),
    .w_gnt(w_gnt), .w_rvalid(w_rvalid), .w_rdata(w_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .f_underrun(f_underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] pat(input logic [18:0] a);
    return {5'b10110, a};
  endfunction

  // SRAM model: read data valid one cycle after the read command
  always @(posedge clk) begin
    if (m_en && !m_we) m_rdata <= pat(m_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("rv_exclusive", 32'(f_rvalid && w_rvalid), 32'd0);
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e_mon = sb.pop_front();
      if (e_mon.port == 1'b0) begin
        chk("f_rvalid", 32'(f_rvalid), 32'd1);
        chk("f_rdata", 32'(f_rdata), 32'(e_mon.data));
      end else begin
        chk("w_rvalid", 32'(w_rvalid), 32'd1);
        chk("w_rdata", 32'(w_rdata), 32'(e_mon.data));
      end
    end else begin
      chk("f_rvalid_idle", 32'(f_rvalid), 32'd0);
      chk("w_rvalid_idle", 32'(w_rvalid), 32'd0);
    end
  end

  // Called at posedge+1; drives one cycle, checks grants, queues expected reads.
  task automatic cycle(input logic fs, input logic fr, input logic [18:0] fa,
                       input logic wr, input logic we, input logic [18:0] wa,
                       input logic [23:0] wd, input logic ef, input logic ew);
    frame_start = fs; f_req = fr; f_addr = fa;
    w_req = wr; w_we = we; w_addr = wa; w_wdata = wd;
    @(negedge clk);
    chk("f_gnt", 32'(f_gnt), 32'(ef));
    chk("w_gnt", 32'(w_gnt), 32'(ew));
    if (ef) sb.push_back('{1'b0, pat(fa), cyc + 2});
    if (ew && !we) sb.push_back('{1'b1, pat(wa), cyc + 2});
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 19'd0, 1'b0, 1'b0, 19'd0, 24'd0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_m_en"}, 32'(m_en), 32'd0);
    chk({tag, "_m_we"}, 32'(m_we), 32'd0);
    chk({tag, "_m_addr"}, 32'(m_addr), 32'd0);
    chk({tag, "_m_wdata"}, 32'(m_wdata), 32'd0);
    chk({tag, "_underrun"}, 32'(f_underrun), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; frame_start = 1'b0;
    f_req = 1'b1; f_addr = 19'h00055;
    w_req = 1'b1; w_we = 1'b1; w_addr = 19'h00066; w_wdata = 24'h123456;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_f_gnt", 32'(f_gnt), 32'd0);
    chk("rst_w_gnt", 32'(w_gnt), 32'd0);
    chk_reset_vals("rst");
    @(posedge clk); #1;
    reset = 1'b0;
    idle();
    chk("post_rst_underrun", 32'(f_underrun), 32'd0);

    // Single fetch read
    cycle(1'b0, 1'b1, 19'h00010, 1'b0, 1'b0, 19'd0, 24'd0, 1'b1, 1'b0);
    chk("fr_m_en", 32'(m_en), 32'd1);
    chk("fr_m_we", 32'(m_we), 32'd0);
    chk("fr_m_addr", 32'(m_addr), 32'h00010);
    idle(); idle();

    // Single writer write
    cycle(1'b0, 1'b0, 19'd0, 1'b1, 1'b1, 19'h12345, 24'hFF8000, 1'b0, 1'b1);
    chk("wr_m_en", 32'(m_en), 32'd1);
    chk("wr_m_we", 32'(m_we), 32'd1);
    chk("wr_m_addr", 32'(m_addr), 32'h12345);
    chk("wr_m_wdata", 32'(m_wdata), 32'hFF8000);
    idle();
    chk("idle_m_en", 32'(m_en), 32'd0);
    chk("idle_m_we", 32'(m_we), 32'd0);
    chk("idle_m_addr_hold", 32'(m_addr), 32'h12345);
    idle();

    // Alternating fetch / writer reads
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0)
        cycle(1'b0, 1'b1, 19'(19'h00100 + i), 1'b0, 1'b0, 19'd0, 24'd0, 1'b1, 1'b0);
      else
        cycle(1'b0, 1'b0, 19'd0, 1'b1, 1'b0, 19'(19'h00200 + i), 24'd0, 1'b0, 1'b1);
    end
    idle(); idle();
    chk("alt_underrun", 32'(f_underrun), 32'd0);

    // Both held: writer served once every 18 cycles
    for (int i = 0; i < 54; i++) begin
      cycle(1'b0, 1'b1, 19'(19'h03000 + i), 1'b1, 1'b0, 19'(19'h04000 + i), 24'd0,
            (i % 18) != 17, (i % 18) == 17);
      if (i == 16) chk("starve_underrun_pre", 32'(f_underrun), 32'd0);
      if (i == 17) chk("starve_underrun_set", 32'(f_underrun), 32'd1);
    end
    idle();

    // Counter at limit in the same cycle as a W grant must not starve
    for (int i = 0; i < 16; i++)
      cycle(1'b0, 1'b1, 19'(19'h05000 + i), 1'b1, 1'b0, 19'(19'h06000 + i), 24'd0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 19'd0, 1'b1, 1'b0, 19'h06100, 24'd0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 19'h05100, 1'b1, 1'b0, 19'h06101, 24'd0, 1'b1, 1'b0);
    idle();

    // STARVE with writer gone behaves as NORMAL, then returns to NORMAL
    for (int i = 0; i < 17; i++)
      cycle(1'b0, 1'b1, 19'(19'h07000 + i), 1'b1, 1'b0, 19'(19'h08000 + i), 24'd0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 19'h07100, 1'b0, 1'b0, 19'd0, 24'd0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 19'h07101, 1'b1, 1'b0, 19'h08101, 24'd0, 1'b1, 1'b0);

    // frame_start clears underrun; refusal in the same cycle wins
    cycle(1'b1, 1'b0, 19'd0, 1'b0, 1'b0, 19'd0, 24'd0, 1'b0, 1'b0);
    chk("fs_clear", 32'(f_underrun), 32'd0);
    for (int i = 0; i < 17; i++)
      cycle(1'b0, 1'b1, 19'(19'h09000 + i), 1'b1, 1'b0, 19'(19'h0A000 + i), 24'd0, 1'b1, 1'b0);
    chk("fs_pre_refuse", 32'(f_underrun), 32'd0);
    cycle(1'b1, 1'b1, 19'h09100, 1'b1, 1'b0, 19'h0A100, 24'd0, 1'b0, 1'b1);
    chk("fs_with_refuse", 32'(f_underrun), 32'd1);
    cycle(1'b1, 1'b0, 19'd0, 1'b0, 1'b0, 19'd0, 24'd0, 1'b0, 1'b0);
    chk("fs_next_frame", 32'(f_underrun), 32'd0);
    idle();

    // Reset one cycle after a fetch grant discards the read
    cycle(1'b0, 1'b1, 19'h00777, 1'b0, 1'b0, 19'd0, 24'd0, 1'b1, 1'b0);
    sb.delete();
    reset = 1'b1; f_req = 1'b0;
    @(negedge clk);
    chk("mid_rst_f_gnt", 32'(f_gnt), 32'd0);
    chk("mid_rst_w_gnt", 32'(w_gnt), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk_reset_vals("mid_rst");
    idle(); idle(); idle();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
`default_nettype wire
